fp_accumulator: RTL
===================

// Module: fp_accumulator
// PURPOSE
//   Sequential FP32 accumulator directly downstream of fp_multiplier. Sums a stream of FP32 products
//   (one dot-product vector, terminated by in_last) and emits one FP32 total per vector.
//   Valid/ready on both sides; one term in flight (no read-after-write hazard on the accumulator).
// PARAMETERS
//   EXPONENT_WIDTH  8    exponent field width
//   MANTISSA_WIDTH  23   stored mantissa field width
//   WIDTH           32   1 + EXPONENT_WIDTH + MANTISSA_WIDTH
//   GUARD_BITS      3    guard/round/sticky bits kept below the LSB through align/add
//   COUNT_WIDTH     16   width of the term counter
// PORTS
//   clk        in   1            clock, rising edge
//   rst        in   1            asynchronous, active-low reset
//   in_valid   in   1            product term valid
//   in_ready   out  1            block can accept a term
//   in_data    in   WIDTH        FP32 term {sign, exponent, mantissa}
//   in_last    in   1            term is the final one of the vector
//   out_valid  out  1            total valid
//   out_ready  in   1            consumer accepts total
//   out_data   out  WIDTH        FP32 total
//   out_count  out  COUNT_WIDTH  number of terms summed into out_data (saturating)
// BEHAVIOUR
//   - Reset (rst low, async): state IDLE, accumulator +0.0, count 0, in_ready 0 while rst low,
//     out_valid 0, out_data 0, out_count 0.
//   - FSM: IDLE -> ALIGN -> ADD -> (last_q ? OUT : IDLE); OUT -> IDLE on out_ready.
//     IDLE: in_ready=1; accept on in_valid&in_ready; register in_data and in_last.
//     ALIGN: compare exponents, right-shift the smaller significand (hidden 1 restored) by the
//       exponent difference; bits shifted out OR into sticky; shift >= MANTISSA_WIDTH+GUARD_BITS+2
//       leaves only sticky.
//     ADD: signed-magnitude add/subtract, leading-one normalise, round (see CONFIGURATION),
//       write accumulator, count+1 (saturates at all-ones).
//     OUT: out_valid=1, out_data/out_count held stable until out_ready; on handshake accumulator
//       -> +0.0, count -> 0, next vector starts.
//   - Latency: last term accepted at edge E0 -> out_valid visible after E0+2.
//     Throughput: one term per 3 cycles.
//   - Arithmetic: exponent field 0 treated as zero (denormals flushed); result exponent underflow
//     -> +0.0.
//     Overflow (or exponent field all-ones on input) saturates to +/-max finite (0x7F7FFFFF/0xFF7FFFFF).
//     Exact cancellation gives +0.0. No NaN/Inf produced.
//   - Single-term vector: out_data equals in_data (subject to flush/saturate rules).
//   - in_ready is 0 in ALIGN, ADD and OUT; in_valid ignored there. out_ready ignored outside OUT.
//   - Reset mid-operation discards the partial sum and any pending output immediately.
// CONFIGURATION
//   FP_ACCUMULATOR_ROUND_EN defined: round-to-nearest-even using guard/round/sticky; a rounding
//     carry renormalises (exponent+1, may saturate).
//   Undefined: truncate toward zero; guard bits discarded; ADD logic identical otherwise.
// STRUCTURE
//   Package fp_pkg: field widths, exponent bias (127), max-finite constants, FSM state encodings
//     (IDLE/ALIGN/ADD/OUT), unpack/pack functions.
//   Sub-module fp_align_shift: right barrel shift with sticky-OR of shifted-out bits, used in ALIGN.
//   Leading-zero count and rounding stay inline in fp_accumulator.
// TESTING
//   1. 0x3F800000 then 0x40000000 (last) -> out_data 0x40400000 (3.0), out_count 2, out_valid
//      2 cycles after last accept.
//   2. 0x3FC00000 then 0xBFC00000 (last) -> 0x00000000, out_count 2.
//   3. Single term 0xC0A00000 (last) -> 0xC0A00000, out_count 1.
//   4. 0x7F7FFFFF + 0x7F7FFFFF (last) -> 0x7F7FFFFF; 0x00400000 + 0x3F800000 (last) -> 0x3F800000.
//   5. 0x3F800000 + 0x33C00000 (last) -> 0x3F800001 with FP_ACCUMULATOR_ROUND_EN,
//      0x3F800000 without.
//   6. out_ready low 5 cycles in OUT -> out_data stable, in_ready 0; after handshake next vector
//      {0x40000000 last} -> 0x40000000.
//      rst low during ADD -> out_valid 0, in_ready 0 during reset; after release an IDLE sum
//      starts from 0.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared FP32 field widths, constants, FSM encoding and pack/unpack
// helpers for the FP accumulator.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int FP_W  = 1 + EXP_W + MAN_W;
  localparam int GRD_W = 3;
  localparam int SIG_W = 1 + MAN_W + GRD_W;  // hidden 1 + mantissa + guard/round/sticky
  localparam int LZ_W  = $clog2(SIG_W);
  localparam int BIAS  = 127;

  localparam logic [EXP_W-1:0] EXP_MAX_FIN = EXP_W'(2 * BIAS);
  localparam logic [FP_W-1:0]  MAX_POS     = 32'h7F7FFFFF;
  localparam logic [FP_W-1:0]  MAX_NEG     = 32'hFF7FFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_ADD   = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Working operand: extended significand with guard bits appended.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp_unp_t;

  // Denormals flush to +0; an all-ones exponent becomes max finite.
  function automatic fp_unp_t fp_unpack(input logic [FP_W-1:0] x);
    fp_unp_t u;
    u.sign = x[FP_W-1];
    u.exp  = x[FP_W-2:MAN_W];
    u.sig  = {1'b1, x[MAN_W-1:0], {GRD_W{1'b0}}};
    if (u.exp == '0) begin
      u.sign = 1'b0;
      u.sig  = '0;
    end else if (u.exp == '1) begin
      u.exp = EXP_MAX_FIN;
      u.sig = {1'b1, {MAN_W{1'b1}}, {GRD_W{1'b0}}};
    end
    return u;
  endfunction

  function automatic logic [FP_W-1:0] fp_pack(input logic sign, input logic [EXP_W-1:0] exp,
                                              input logic [MAN_W-1:0] man);
    return {sign, exp, man};
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// fp_align_shift: right shift of an extended significand; every bit shifted
// out is OR-ed into the result LSB (sticky). Shifts >= LIMIT leave only sticky.
module fp_align_shift #(
  parameter int W     = 27,
  parameter int SHW   = 8,
  parameter int LIMIT = 28
) (
  input  logic [W-1:0]   din,
  input  logic [SHW-1:0] shamt,
  output logic [W-1:0]   dout
);

  logic [W-1:0] shifted;
  logic [W-1:0] mask;
  logic         lost;

  // Shift and collect lost bits into the sticky position
  always_comb begin
    shifted = '0;
    mask    = '0;
    lost    = 1'b0;
    if (shamt >= SHW'(LIMIT)) begin
      lost = |din;
    end else begin
      shifted = din >> shamt;
      mask    = ~({W{1'b1}} << shamt);
      lost    = |(din & mask);
    end
    dout = {shifted[W-1:1], shifted[0] | lost};
  end

endmodule

// File: rtl/fp_accumulator.sv
// fp_accumulator: sums a stream of FP32 terms (one vector, ended by in_last)
// and emits one FP32 total per vector. One term in flight, 3 cycles per term.
// Build option: FP_ACCUMULATOR_ROUND_EN selects round-to-nearest-even;
// without it results truncate toward zero.
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int WIDTH          = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH,
  parameter int GUARD_BITS     = 3,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [COUNT_WIDTH-1:0] out_count
);

`ifdef FP_ACCUMULATOR_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  state_t                 state, state_nxt;
  fp_unp_t                term_q, acc_u, big, sml, big_q;
  logic                   sml_sign_q;
  logic [SIG_W-1:0]       sml_al, sml_sig_q;
  logic [EXP_W-1:0]       shamt;
  logic                   last_q;
  logic [FP_W-1:0]        acc, acc_nxt;
  logic [COUNT_WIDTH-1:0] count;
  logic                   accept;

  logic                   eff_sub, found, round_up;
  logic [SIG_W:0]         sum;
  logic [SIG_W-1:0]       norm;
  logic [LZ_W-1:0]        lz;
  logic signed [EXP_W+2:0] exp_n, exp_r;
  logic [MAN_W+1:0]       man_r;
  logic [MAN_W-1:0]       man_f;

  assign accept    = in_valid & in_ready;
  assign out_data  = acc;
  assign out_count = count;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ALIGN;
      ST_ALIGN: state_nxt = ST_ADD;
      ST_ADD:   state_nxt = last_q ? ST_OUT : ST_IDLE;
      ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs; in_ready also masked while reset is held
  always_comb begin
    in_ready  = (state == ST_IDLE) && rst;
    out_valid = (state == ST_OUT);
  end

  // Pick the larger-magnitude operand; the smaller one gets aligned to it
  always_comb begin
    acc_u = fp_unpack(acc);
    if ({acc_u.exp, acc_u.sig} >= {term_q.exp, term_q.sig}) begin
      big = acc_u;
      sml = term_q;
    end else begin
      big = term_q;
      sml = acc_u;
    end
  end

  assign shamt = big.exp - sml.exp;

  fp_align_shift #(
    .W    (SIG_W),
    .SHW  (EXP_W),
    .LIMIT(MANTISSA_WIDTH + GUARD_BITS + 2)
  ) u_align (
    .din  (sml.sig),
    .shamt(shamt),
    .dout (sml_al)
  );

  // Add/sub magnitudes, normalise, round, then flush/saturate the exponent
  always_comb begin
    eff_sub = big_q.sign ^ sml_sign_q;
    sum = eff_sub ? ({1'b0, big_q.sig} - {1'b0, sml_sig_q})
                  : ({1'b0, big_q.sig} + {1'b0, sml_sig_q});
    lz    = '0;
    found = 1'b0;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz    = LZ_W'(SIG_W - 1 - i);
        found = 1'b1;
      end
    end
    if (sum[SIG_W]) begin
      // carry out: shift right one, keep the dropped bit as sticky
      norm  = {sum[SIG_W:2], |sum[1:0]};
      exp_n = $signed({3'b000, big_q.exp}) + 11'sd1;
    end else begin
      norm  = sum[SIG_W-1:0] << lz;
      exp_n = $signed({3'b000, big_q.exp}) - $signed({6'b000000, lz});
    end
    round_up = ROUND_EN && norm[GRD_W-1] && ((|norm[GRD_W-2:0]) || norm[GRD_W]);
    man_r    = {1'b0, norm[SIG_W-1:GRD_W]} + {{(MAN_W+1){1'b0}}, round_up};
    exp_r    = exp_n;
    man_f    = man_r[MAN_W-1:0];
    if (man_r[MAN_W+1]) begin
      // rounding carried into a new leading one
      exp_r = exp_n + 11'sd1;
      man_f = man_r[MAN_W:1];
    end
    if (sum == '0 || exp_r <= 11'sd0)
      acc_nxt = '0;
    else if (exp_r > $signed({3'b000, EXP_MAX_FIN}))
      acc_nxt = big_q.sign ? MAX_NEG : MAX_POS;
    else
      acc_nxt = fp_pack(big_q.sign, exp_r[EXP_W-1:0], man_f);
  end

  // Datapath registers, advanced by the FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      term_q     <= '0;
      last_q     <= 1'b0;
      big_q      <= '0;
      sml_sign_q <= 1'b0;
      sml_sig_q  <= '0;
      acc        <= '0;
      count      <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          term_q <= fp_unpack(in_data);
          last_q <= in_last;
        end
        ST_ALIGN: begin
          big_q      <= big;
          sml_sign_q <= sml.sign;
          sml_sig_q  <= sml_al;
        end
        ST_ADD: begin
          acc <= acc_nxt;
          if (count != '1) count <= count + 1'b1;
        end
        ST_OUT: if (out_ready) begin
          acc   <= '0;
          count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
